// File: rtl/prbs_pkg.sv
// Shared PRBS31 constants, FSM encoding and the TX beat payload for the PRBS generator/checker family.
package prbs_pkg;

  localparam int unsigned POLY_LEN = 31;
  localparam int unsigned POLY_TAP = 28;
  localparam int unsigned WORD_W   = 32;

  localparam logic [POLY_LEN-1:0] DEFAULT_SEED = 31'h7FFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              last;
    logic              user;
  } beat_t;

endpackage

// File: rtl/prbs31_step.sv
// Combinational 32-bit-step PRBS31 (x^31 + x^28 + 1) advance: returns the next state and the raw
// (non-inverted) feedback bits, first bit produced in data_o[31].
module prbs31_step
  import prbs_pkg::*;
(
  input  logic [POLY_LEN-1:0] state_i,
  output logic [POLY_LEN-1:0] state_o,
  output logic [WORD_W-1:0]   data_o
);

  logic [POLY_LEN-1:0] s;
  logic                fb;

  always_comb begin
    s      = state_i;
    fb     = 1'b0;
    data_o = '0;
    for (int i = 0; i < int'(WORD_W); i++) begin
      fb                  = s[POLY_LEN-1] ^ s[POLY_TAP-1];
      data_o[WORD_W-1-i]  = fb;
      s                   = {s[POLY_LEN-2:0], fb};
    end
    state_o = s;
  end

endmodule

// File: rtl/prbs_gen.sv
// PRBS31 framed packet source for PHY loopback; fixed-length packets with valid/ready and inter-packet gap.
// Optional one-shot bit-0 error injection is enabled by defining PRBS_GEN_ERR_INJ_EN.
module prbs_gen
  import prbs_pkg::*;
#(
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        PKT_BEATS  = 256,
  parameter int unsigned        GAP_CYCLES = 4,
  parameter logic [POLY_LEN-1:0] SEED      = DEFAULT_SEED
) (
  input  logic              tx_user_clk_i,
  input  logic              tx_user_rst_i,
  input  logic              gen_en_i,
  input  logic              tx_ready_i,
`ifdef PRBS_GEN_ERR_INJ_EN
  input  logic              err_inj_i,
  output logic [7:0]        err_inj_cnt_o,
`endif
  output logic [DATA_W-1:0] tx_data_o,
  output logic [1:0]        tx_vldb_o,
  output logic              tx_valid_o,
  output logic              tx_last_o,
  output logic              tx_user_o,
  output logic [15:0]       pkt_cnt_o,
  output logic              busy_o
);

  localparam int unsigned BEAT_W = (PKT_BEATS > 2) ? $clog2(PKT_BEATS) : 1;
  localparam int unsigned GAP_W  = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_BEATS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [POLY_LEN-1:0] lfsr_q, lfsr_d;
  logic [15:0]         pkt_q, pkt_d;
  beat_t               out_q, out_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                accept, load;
  logic [POLY_LEN-1:0] step_state;
  logic [WORD_W-1:0]   step_data;

  prbs31_step u_step (
    .state_i (lfsr_q),
    .state_o (step_state),
    .data_o  (step_data)
  );

`ifdef PRBS_GEN_ERR_INJ_EN
  logic       armed_q, armed_d;
  logic [7:0] err_cnt_q, err_cnt_d;
`endif

  // lfsr_q always holds the state just after the word currently loaded in out_q
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    pkt_d   = pkt_q;
    load    = 1'b0;
    accept  = (state_q == SEND) && tx_ready_i;

    case (state_q)
      IDLE: begin
        if (gen_en_i) begin
          state_d = SEND;
          load    = 1'b1;
        end
      end
      SEND: begin
        if (accept) begin
          if (beat_q == LAST_BEAT) begin
            pkt_d  = pkt_q + 16'd1;
            beat_d = '0;
            if (GAP_CYCLES == 0) begin
              if (gen_en_i) load = 1'b1;
              else          state_d = IDLE;
            end else begin
              state_d = GAP;
              gap_d   = '0;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
            load   = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          if (gen_en_i) begin
            state_d = SEND;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    lfsr_d = load ? step_state : lfsr_q;
    out_d  = out_q;
    if (load) out_d.data = ~step_data;

`ifdef PRBS_GEN_ERR_INJ_EN
    armed_d   = armed_q;
    err_cnt_d = err_cnt_q;
    if (load && armed_q) begin
      out_d.data[0] = ~out_d.data[0];
      armed_d       = 1'b0;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end else if (err_inj_i) begin
      armed_d = 1'b1;
    end
`endif

    out_d.last = (beat_d == LAST_BEAT);
    out_d.user = (beat_d == '0);
    if (state_d != SEND) out_d = '0;
    valid_d = (state_d == SEND);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge tx_user_clk_i) begin
    if (tx_user_rst_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
      gap_q   <= '0;
      lfsr_q  <= SEED;
      pkt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      lfsr_q  <= lfsr_d;
      pkt_q   <= pkt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

`ifdef PRBS_GEN_ERR_INJ_EN
  always_ff @(posedge tx_user_clk_i) begin
    if (tx_user_rst_i) begin
      armed_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      armed_q   <= armed_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_inj_cnt_o = err_cnt_q;
`endif

  assign tx_data_o  = DATA_W'(out_q.data);
  assign tx_vldb_o  = 2'b00;
  assign tx_valid_o = valid_q;
  assign tx_last_o  = out_q.last;
  assign tx_user_o  = out_q.user;
  assign pkt_cnt_o  = pkt_q;
  assign busy_o     = busy_q;

endmodule
